sequencer_rw_mgr_arbiter: RTL and testbench

Two-master Avalon-MM arbiter that shares the single Avalon slave port of the sequencer read/write manager between the calibration CPU (master 0) and the tracking/debug master (master 1). It sits on the sequencer Avalon clock domain, directly in front of the rw_mgr slave. It grants one whole transaction at a time with round-robin fairness and supports an optional lock for multi-access sequences. A watchdog terminates any transaction the rw_mgr fails to complete.

---
 rtl/sequencer_rw_mgr_arbiter.sv | 145 ++++++++++++++
 tb/tb_sequencer_rw_mgr_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sequencer_rw_mgr_arbiter.sv
// Two-master Avalon-MM arbiter in front of the rw_mgr slave: whole-transaction
// round-robin grants, optional lock, and a stall watchdog that forces a termination.
module sequencer_rw_mgr_arbiter #(
   parameter int                        AVL_DATA_WIDTH    = 32,
   parameter int                        AVL_ADDRESS_WIDTH = 16,
   parameter int                        TIMEOUT_CYCLES    = 4096,
   parameter logic [AVL_DATA_WIDTH-1:0] ERR_DATA          = 32'hDEAD_BEEF
) (
   input  logic                         avl_clk,
   input  logic                         avl_reset,
   input  logic [AVL_ADDRESS_WIDTH-1:0] m0_address,
   input  logic                         m0_write,
   input  logic                         m0_read,
   input  logic [AVL_DATA_WIDTH-1:0]    m0_writedata,
   input  logic                         m0_lock,
   output logic [AVL_DATA_WIDTH-1:0]    m0_readdata,
   output logic                         m0_waitrequest,
   input  logic [AVL_ADDRESS_WIDTH-1:0] m1_address,
   input  logic                         m1_write,
   input  logic                         m1_read,
   input  logic [AVL_DATA_WIDTH-1:0]    m1_writedata,
   input  logic                         m1_lock,
   output logic [AVL_DATA_WIDTH-1:0]    m1_readdata,
   output logic                         m1_waitrequest,
   output logic [AVL_ADDRESS_WIDTH-1:0] s_address,
   output logic                         s_write,
   output logic                         s_read,
   output logic [AVL_DATA_WIDTH-1:0]    s_writedata,
   input  logic [AVL_DATA_WIDTH-1:0]    s_readdata,
   input  logic                         s_waitrequest,
   output logic [1:0]                   grant,
   output logic                         timeout_err,
   input  logic                         err_clear
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      TERM   = 2'd2
   } state_t;

   localparam bit          WD_EN    = (TIMEOUT_CYCLES != 0);
   localparam logic [15:0] CNT_LAST = WD_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

   state_t      state;
   logic        owner;
   logic        last_owner;
   logic [15:0] stall_cnt;

   logic req0, req1, own_req, own_lock, stalled, wd_fire;

   assign req0     = m0_read | m0_write;
   assign req1     = m1_read | m1_write;
   assign own_req  = owner ? req1 : req0;
   assign own_lock = owner ? m1_lock : m0_lock;
   assign stalled  = (state == ACTIVE) && own_req && s_waitrequest;
   assign wd_fire  = WD_EN && stalled && (stall_cnt == CNT_LAST);

   always_ff @(posedge avl_clk or posedge avl_reset) begin
      if (avl_reset) begin
         state       <= IDLE;
         owner       <= 1'b0;
         last_owner  <= 1'b1;
         stall_cnt   <= 16'd0;
         timeout_err <= 1'b0;
      end else begin
         // a new timeout beats a simultaneous clear
         if (wd_fire)
            timeout_err <= 1'b1;
         else if (err_clear)
            timeout_err <= 1'b0;

         case (state)
            IDLE: begin
               if (req0 | req1) begin
                  owner     <= (req0 & req1) ? ~last_owner : req1;
                  state     <= ACTIVE;
                  stall_cnt <= 16'd0;
               end
            end
            ACTIVE: begin
               if (own_req && !s_waitrequest) begin
                  last_owner <= owner;
                  stall_cnt  <= 16'd0;
                  if (!own_lock)
                     state <= IDLE;
               end else if (own_req) begin
                  if (wd_fire)
                     state <= TERM;
                  else if (WD_EN)
                     stall_cnt <= stall_cnt + 16'd1;
               end else if (!own_lock) begin
                  state <= IDLE;
               end
            end
            TERM: begin
               last_owner <= owner;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      s_address      = '0;
      s_write        = 1'b0;
      s_read         = 1'b0;
      s_writedata    = '0;
      m0_waitrequest = req0;
      m1_waitrequest = req1;
      m0_readdata    = '0;
      m1_readdata    = '0;
      grant          = 2'b00;
      case (state)
         ACTIVE: begin
            grant       = owner ? 2'b10 : 2'b01;
            s_address   = owner ? m1_address : m0_address;
            s_write     = owner ? m1_write : m0_write;
            s_read      = owner ? m1_read : m0_read;
            s_writedata = owner ? m1_writedata : m0_writedata;
            if (owner) begin
               m1_waitrequest = s_waitrequest;
               m1_readdata    = s_readdata;
            end else begin
               m0_waitrequest = s_waitrequest;
               m0_readdata    = s_readdata;
            end
         end
         TERM: begin
            // release the owner with the error pattern; the slave sees nothing
            grant = owner ? 2'b10 : 2'b01;
            if (owner) begin
               m1_waitrequest = 1'b0;
               m1_readdata    = ERR_DATA;
            end else begin
               m0_waitrequest = 1'b0;
               m0_readdata    = ERR_DATA;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sequencer_rw_mgr_arbiter.sv
// Directed bench for sequencer_rw_mgr_arbiter: a per-cycle vector table plus
// hand-written round-robin, watchdog, reset and watchdog-disabled sequences.
module tb_sequencer_rw_mgr_arbiter;

   localparam logic [15:0] A0 = 16'h0100;
   localparam logic [15:0] A1 = 16'h0200;
   localparam logic [31:0] D0 = 32'h1111_0000;
   localparam logic [31:0] D1 = 32'h2222_0000;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic        avl_clk = 1'b0;
   logic        avl_reset;
   logic [15:0] m0_address, m1_address;
   logic        m0_write, m0_read, m0_lock, m1_write, m1_read, m1_lock;
   logic [31:0] m0_writedata, m1_writedata, s_readdata;
   logic        s_waitrequest, err_clear;

   logic [31:0] m0_readdata, m1_readdata, s_writedata;
   logic        m0_waitrequest, m1_waitrequest, s_write, s_read, timeout_err;
   logic [15:0] s_address;
   logic [1:0]  grant;

   logic [31:0] n_m0_readdata, n_m1_readdata, n_s_writedata;
   logic        n_m0_waitrequest, n_m1_waitrequest, n_s_write, n_s_read, n_timeout_err;
   logic [15:0] n_s_address;
   logic [1:0]  n_grant;

   int n_checks = 0;
   int n_errors = 0;

   always #5 avl_clk = ~avl_clk;

   sequencer_rw_mgr_arbiter #(.TIMEOUT_CYCLES(16)) u_dut (
      .avl_clk(avl_clk), .avl_reset(avl_reset),
      .m0_address(m0_address), .m0_write(m0_write), .m0_read(m0_read),
      .m0_writedata(m0_writedata), .m0_lock(m0_lock),
      .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
      .m1_address(m1_address), .m1_write(m1_write), .m1_read(m1_read),
      .m1_writedata(m1_writedata), .m1_lock(m1_lock),
      .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
      .s_address(s_address), .s_write(s_write), .s_read(s_read),
      .s_writedata(s_writedata), .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
      .grant(grant), .timeout_err(timeout_err), .err_clear(err_clear)
   );

   sequencer_rw_mgr_arbiter #(.TIMEOUT_CYCLES(0)) u_dut_nowd (
      .avl_clk(avl_clk), .avl_reset(avl_reset),
      .m0_address(m0_address), .m0_write(m0_write), .m0_read(m0_read),
      .m0_writedata(m0_writedata), .m0_lock(m0_lock),
      .m0_readdata(n_m0_readdata), .m0_waitrequest(n_m0_waitrequest),
      .m1_address(m1_address), .m1_write(m1_write), .m1_read(m1_read),
      .m1_writedata(m1_writedata), .m1_lock(m1_lock),
      .m1_readdata(n_m1_readdata), .m1_waitrequest(n_m1_waitrequest),
      .s_address(n_s_address), .s_write(n_s_write), .s_read(n_s_read),
      .s_writedata(n_s_writedata), .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
      .grant(n_grant), .timeout_err(n_timeout_err), .err_clear(err_clear)
   );

   typedef struct {
      logic [5:0]  mreq;   // {m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock}
      logic        sw;
      logic [31:0] srdata;
      logic        clr;
      logic [1:0]  g;
      logic [3:0]  ws;     // {m0_waitrequest, m1_waitrequest, s_read, s_write}
      logic [15:0] saddr;
      logic [31:0] r0;
      logic [31:0] r1;
      logic        te;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [5:0] mreq, logic sw, logic [31:0] srdata, logic clr,
                               logic [1:0] g, logic [3:0] ws, logic [15:0] saddr,
                               logic [31:0] r0, logic [31:0] r1, logic te);
      vec_t v;
      v.mreq = mreq; v.sw = sw; v.srdata = srdata; v.clr = clr;
      v.g = g; v.ws = ws; v.saddr = saddr; v.r0 = r0; v.r1 = r1; v.te = te;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge avl_clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_read = 0; m0_write = 0; m0_lock = 0;
      m1_read = 0; m1_write = 0; m1_lock = 0;
      s_waitrequest = 0; s_readdata = 0; err_clear = 0;
   endtask

   task automatic do_reset();
      avl_reset = 1'b1;
      idle_inputs();
      repeat (2) @(posedge avl_clk);
      #1 avl_reset = 1'b0;
   endtask

   initial begin
      int bad;
      m0_address = A0; m1_address = A1;
      m0_writedata = D0; m1_writedata = D1;

      // ---------------- vector table ----------------
      vecs.push_back(mk(6'b000_000, 0, 32'h0,    0, 2'b00, 4'b0000, 16'h0, 32'h0,    32'h0,    0));
      vecs.push_back(mk(6'b100_000, 1, 32'h0,    0, 2'b00, 4'b1000, 16'h0, 32'h0,    32'h0,    0));
      vecs.push_back(mk(6'b100_000, 1, 32'h0,    0, 2'b01, 4'b1010, A0,    32'h0,    32'h0,    0));
      vecs.push_back(mk(6'b100_000, 0, 32'hA5,   0, 2'b01, 4'b0010, A0,    32'hA5,   32'h0,    0));
      vecs.push_back(mk(6'b000_000, 1, 32'hA5,   0, 2'b00, 4'b0000, 16'h0, 32'h0,    32'h0,    0));
      vecs.push_back(mk(6'b000_011, 0, 32'h0,    0, 2'b00, 4'b0100, 16'h0, 32'h0,    32'h0,    0));
      vecs.push_back(mk(6'b010_011, 0, 32'h77,   0, 2'b10, 4'b1001, A1,    32'h0,    32'h77,   0));
      vecs.push_back(mk(6'b010_001, 0, 32'h0,    0, 2'b10, 4'b1000, A1,    32'h0,    32'h0,    0));
      vecs.push_back(mk(6'b010_011, 1, 32'h0,    0, 2'b10, 4'b1101, A1,    32'h0,    32'h0,    0));
      vecs.push_back(mk(6'b010_011, 0, 32'h0,    0, 2'b10, 4'b1001, A1,    32'h0,    32'h0,    0));
      vecs.push_back(mk(6'b010_001, 0, 32'h0,    0, 2'b10, 4'b1000, A1,    32'h0,    32'h0,    0));
      vecs.push_back(mk(6'b010_010, 0, 32'h0,    0, 2'b10, 4'b1001, A1,    32'h0,    32'h0,    0));
      vecs.push_back(mk(6'b010_000, 0, 32'h0,    0, 2'b00, 4'b1000, 16'h0, 32'h0,    32'h0,    0));
      vecs.push_back(mk(6'b010_000, 0, 32'h55,   0, 2'b01, 4'b0001, A0,    32'h55,   32'h0,    0));
      vecs.push_back(mk(6'b000_100, 1, 32'h0,    0, 2'b00, 4'b0100, 16'h0, 32'h0,    32'h0,    0));
      vecs.push_back(mk(6'b000_100, 0, 32'h1234, 0, 2'b10, 4'b0010, A1,    32'h0,    32'h1234, 0));
      vecs.push_back(mk(6'b100_100, 1, 32'h0,    0, 2'b00, 4'b1100, 16'h0, 32'h0,    32'h0,    0));
      vecs.push_back(mk(6'b100_100, 0, 32'h9,    0, 2'b01, 4'b0110, A0,    32'h9,    32'h0,    0));
      vecs.push_back(mk(6'b100_100, 1, 32'h0,    0, 2'b00, 4'b1100, 16'h0, 32'h0,    32'h0,    0));
      vecs.push_back(mk(6'b100_100, 0, 32'h3,    0, 2'b10, 4'b1010, A1,    32'h0,    32'h3,    0));
      vecs.push_back(mk(6'b000_000, 0, 32'h0,    0, 2'b00, 4'b0000, 16'h0, 32'h0,    32'h0,    0));
      vecs.push_back(mk(6'b100_000, 1, 32'h0,    0, 2'b00, 4'b1000, 16'h0, 32'h0,    32'h0,    0));
      vecs.push_back(mk(6'b000_000, 1, 32'h0,    0, 2'b01, 4'b1000, A0,    32'h0,    32'h0,    0));
      vecs.push_back(mk(6'b000_000, 0, 32'h0,    0, 2'b00, 4'b0000, 16'h0, 32'h0,    32'h0,    0));

      do_reset();
      foreach (vecs[i]) begin
         {m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock} = vecs[i].mreq;
         s_waitrequest = vecs[i].sw;
         s_readdata    = vecs[i].srdata;
         err_clear     = vecs[i].clr;
         @(negedge avl_clk);
         chk($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].g));
         chk($sformatf("v%0d wait/strobe", i),
             32'({m0_waitrequest, m1_waitrequest, s_read, s_write}), 32'(vecs[i].ws));
         chk($sformatf("v%0d s_address", i), 32'(s_address), 32'(vecs[i].saddr));
         chk($sformatf("v%0d m0_readdata", i), m0_readdata, vecs[i].r0);
         chk($sformatf("v%0d m1_readdata", i), m1_readdata, vecs[i].r1);
         chk($sformatf("v%0d timeout_err", i), 32'(timeout_err), 32'(vecs[i].te));
         tick();
      end

      // ---------------- round robin out of reset ----------------
      do_reset();
      m0_write = 1; m1_write = 1;
      for (int k = 0; k < 16; k++) begin
         @(negedge avl_clk);
         if (k % 2 == 0) begin
            chk($sformatf("rr%0d idle grant", k), 32'(grant), 32'd0);
            chk($sformatf("rr%0d idle waits", k), 32'({m0_waitrequest, m1_waitrequest, s_write}), 32'b110);
         end else begin
            int own;
            own = ((k - 1) / 2) % 2;
            chk($sformatf("rr%0d grant", k), 32'(grant), (own == 1) ? 32'b10 : 32'b01);
            chk($sformatf("rr%0d waits", k), 32'({m0_waitrequest, m1_waitrequest, s_write}),
                (own == 1) ? 32'b101 : 32'b011);
            chk($sformatf("rr%0d s_writedata", k), s_writedata, (own == 1) ? D1 : D0);
         end
         tick();
      end

      // ---------------- watchdog (TIMEOUT_CYCLES = 16) ----------------
      do_reset();
      m0_write = 1; s_waitrequest = 1;
      @(negedge avl_clk);
      chk("to1 idle grant", 32'(grant), 32'd0);
      tick();
      bad = 0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge avl_clk);
         if (grant !== 2'b01 || m0_waitrequest !== 1'b1 || s_write !== 1'b1) bad++;
         tick();
      end
      chk("to1 stall cycles held", 32'(bad), 32'd0);
      @(negedge avl_clk);
      chk("to1 term grant", 32'(grant), 32'b01);
      chk("to1 term m0_waitrequest", 32'(m0_waitrequest), 32'd0);
      chk("to1 term m0_readdata", m0_readdata, ERR);
      chk("to1 term s_write", 32'(s_write), 32'd0);
      chk("to1 term timeout_err", 32'(timeout_err), 32'd1);
      tick();
      m0_write = 0; err_clear = 1;
      @(negedge avl_clk);
      chk("to1 post grant", 32'(grant), 32'd0);
      chk("to1 sticky err", 32'(timeout_err), 32'd1);
      tick();
      err_clear = 0; m0_write = 1;
      @(negedge avl_clk);
      chk("to1 err cleared", 32'(timeout_err), 32'd0);
      tick();
      // second timeout with err_clear on the final stall cycle
      for (int k = 1; k <= 16; k++) begin
         err_clear = (k == 16);
         @(negedge avl_clk);
         if (k == 16) chk("to2 last stall still waiting", 32'(m0_waitrequest), 32'd1);
         tick();
      end
      err_clear = 0;
      @(negedge avl_clk);
      chk("to2 term m0_readdata", m0_readdata, ERR);
      chk("to2 set beats clear", 32'(timeout_err), 32'd1);
      tick();

      // ---------------- reset mid-transaction ----------------
      m0_write = 0; m0_read = 1;
      tick();
      tick();
      @(negedge avl_clk);
      chk("rst pre grant", 32'(grant), 32'b01);
      chk("rst pre s_read", 32'(s_read), 32'd1);
      tick();
      #2 avl_reset = 1'b1;
      #1;
      chk("rst async grant", 32'(grant), 32'd0);
      chk("rst async s_read", 32'(s_read), 32'd0);
      chk("rst async timeout_err", 32'(timeout_err), 32'd0);
      chk("rst async m0_waitrequest", 32'(m0_waitrequest), 32'd1);
      @(posedge avl_clk);
      #1 avl_reset = 1'b0;
      m0_read = 0; m1_read = 1;
      @(negedge avl_clk);
      chk("rst m1 idle wait", 32'(m1_waitrequest), 32'd1);
      tick();
      @(negedge avl_clk);
      chk("rst m1 granted", 32'(grant), 32'b10);
      tick();

      // ---------------- watchdog disabled ----------------
      do_reset();
      m0_read = 1; s_waitrequest = 1;
      tick();
      bad = 0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge avl_clk);
         if (n_grant !== 2'b01 || n_m0_waitrequest !== 1'b1 || n_timeout_err !== 1'b0) bad++;
         tick();
      end
      chk("nowd held grant", 32'(bad), 32'd0);
      chk("nowd s_read", 32'(n_s_read), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
